// File: rtl/ber_checker.sv
// Single-lane PRBS bit-error-rate checker: searches a reference delay, locks, then counts bits/errors.
// Optional lock-loss/resync on a degraded window is enabled by defining BER_RESYNC_EN.
module ber_checker #(
  parameter int NB_INPUT   = 12,
  parameter int NB_DELAY   = 10,
  parameter int NB_WIN     = 9,
  parameter int NB_CNT     = 64,
  parameter int LOCK_THR   = 0,
  parameter int RESYNC_THR = 16
) (
  input  logic                clk,
  input  logic                i_rst_n,
  input  logic                i_EnbRx,
  input  logic                i_valid,
  input  logic [NB_INPUT-1:0] i_data,
  input  logic                i_prbs_bit,
  input  logic                i_clear,
  output logic                o_locked,
  output logic [NB_DELAY-1:0] o_delay,
  output logic [NB_WIN:0]     o_min_err,
  output logic [NB_CNT-1:0]   o_bit_count,
  output logic [NB_CNT-1:0]   o_err_count,
  output logic                o_led,
  output logic                o_out_bit
);

  localparam int DEPTH = 1 << NB_DELAY;
  localparam logic [NB_DELAY-1:0] D_MAX  = '1;
  localparam logic [NB_WIN-1:0]   W_LAST = '1;
  localparam logic [NB_WIN:0]     LOCK_THR_W   = LOCK_THR[NB_WIN:0];
  localparam logic [NB_WIN:0]     RESYNC_THR_W = RESYNC_THR[NB_WIN:0];
`ifdef BER_RESYNC_EN
  localparam bit RESYNC_EN = 1'b1;
`else
  localparam bit RESYNC_EN = 1'b0;
`endif

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [DEPTH-1:0]    ref_q, ref_d;
  logic [NB_WIN-1:0]   wcnt_q, wcnt_d;
  logic [NB_WIN:0]     werr_q, werr_d;
  logic [NB_WIN:0]     best_q, best_d;
  logic [NB_DELAY-1:0] best_dly_q, best_dly_d;
  logic [NB_DELAY-1:0] delay_q, delay_d;
  logic [NB_WIN:0]     min_err_q, min_err_d;
  logic [NB_CNT-1:0]   bit_cnt_q, bit_cnt_d;
  logic [NB_CNT-1:0]   err_cnt_q, err_cnt_d;
  logic                led_q, led_d;

  logic                step;
  logic                rx_bit;
  logic                mismatch;
  logic                win_end;
  logic [NB_WIN:0]     total;
  logic [NB_WIN:0]     cand_best;
  logic [NB_DELAY-1:0] cand_dly;
  logic                unused_data;

  assign rx_bit      = i_data[NB_INPUT-1];
  assign o_out_bit   = rx_bit;
  assign unused_data = ^i_data[NB_INPUT-2:0];

  always_comb begin
    step      = i_EnbRx & i_valid;
    mismatch  = ref_q[delay_q] ^ rx_bit;
    win_end   = (wcnt_q == W_LAST);
    total     = werr_q + {{NB_WIN{1'b0}}, mismatch};
    cand_best = best_q;
    cand_dly  = best_dly_q;
    if ((total < best_q) || (delay_q == '0)) begin
      cand_best = total;
      cand_dly  = delay_q;
    end

    state_d    = state_q;
    ref_d      = ref_q;
    wcnt_d     = wcnt_q;
    werr_d     = werr_q;
    best_d     = best_q;
    best_dly_d = best_dly_q;
    delay_d    = delay_q;
    min_err_d  = min_err_q;
    bit_cnt_d  = bit_cnt_q;
    err_cnt_d  = err_cnt_q;
    led_d      = led_q;

    if (step) begin
      ref_d  = {ref_q[DEPTH-2:0], i_prbs_bit};
      wcnt_d = wcnt_q + 1'b1;
      werr_d = win_end ? '0 : total;

      case (state_q)
        SEARCH: begin
          if (win_end) begin
            best_d     = cand_best;
            best_dly_d = cand_dly;
            // A perfect window ends the search early at the current candidate.
            if (total == '0) begin
              state_d   = LOCKED;
              min_err_d = cand_best;
            end else if (delay_q == D_MAX) begin
              min_err_d = cand_best;
              if (cand_best <= LOCK_THR_W) begin
                state_d = LOCKED;
                delay_d = cand_dly;
              end else begin
                delay_d = '0;
              end
            end else begin
              delay_d = delay_q + 1'b1;
            end
          end
        end
        LOCKED: begin
          if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + 1'b1;
          if (mismatch && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
          if (RESYNC_EN && win_end && (total > RESYNC_THR_W)) begin
            state_d = SEARCH;
            delay_d = '0;
          end
        end
        default: state_d = SEARCH;
      endcase

      if (win_end) led_d = (state_d == LOCKED) && (total == '0);
    end

    if (i_clear) begin
      bit_cnt_d = '0;
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= SEARCH;
      ref_q      <= '0;
      wcnt_q     <= '0;
      werr_q     <= '0;
      best_q     <= '1;
      best_dly_q <= '0;
      delay_q    <= '0;
      min_err_q  <= '1;
      bit_cnt_q  <= '0;
      err_cnt_q  <= '0;
      led_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ref_q      <= ref_d;
      wcnt_q     <= wcnt_d;
      werr_q     <= werr_d;
      best_q     <= best_d;
      best_dly_q <= best_dly_d;
      delay_q    <= delay_d;
      min_err_q  <= min_err_d;
      bit_cnt_q  <= bit_cnt_d;
      err_cnt_q  <= err_cnt_d;
      led_q      <= led_d;
    end
  end

  assign o_locked    = (state_q == LOCKED);
  assign o_delay     = delay_q;
  assign o_min_err   = min_err_q;
  assign o_bit_count = bit_cnt_q;
  assign o_err_count = err_cnt_q;
  assign o_led       = led_q;

endmodule
